// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA timing generator and the flag designs that
//   consume its coordinates.
//   - Default 640x480@60 timing constants and the derived line/frame totals.
//   - Counter width (fixed at 10 bits, so every total must be <= 1024).
//   - Color width, color type and the blanking value.
//   - sync_level(): maps an "in sync pulse" flag onto the pin level for a
//     given pulse polarity.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 6;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK = 6'b000000;

  // Pin level for a sync output: the pulse polarity while active, its
  // complement otherwise.
  function automatic logic sync_level(input logic active, input logic active_level);
    return active ? active_level : ~active_level;
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter
//   10-bit counter that advances when inc is high and wraps MAX -> 0.
//   Ports:
//     clk   in  1   pixel clock
//     reset in  1   synchronous, active-high; clears count to 0
//     inc   in  1   advance enable
//     count out 10  current value, 0..MAX
//     wrap  out 1   high when count==MAX && inc (the cycle that wraps)
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX = 10'(H_TOTAL_DEF - 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign wrap = inc && (count_reg == MAX);

  always_comb begin
    count_next = count_reg;
    if (inc) begin
      count_next = wrap ? '0 : count_reg + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vga_timing.sv
// vga_timing
//   Pixel timing generator plus output register stage. The coordinate
//   outputs come straight from the counter flops; the flag logic decodes
//   them into color_in combinationally, and this module registers that
//   color (blanked outside the visible area) together with hsync/vsync so
//   all pins change on the same edge, one cycle after the coordinates.
//
//   Optional feature macro: VGA_FRAME_COUNTER_EN
//     defined     -> 8-bit frame counter, +1 on the last pixel of each frame
//     not defined -> frame tied to 0, no counter flops
//
//   Ports:
//     clk         in  1   pixel clock
//     reset       in  1   synchronous, active-high; restarts at (0,0)
//     pix_x       out 10  current column, 0..H_TOTAL-1
//     pix_y       out 10  current row, 0..V_TOTAL-1
//     display_on  out 1   (pix_x,pix_y) inside the visible area
//     color_in    in  6   flag color for the current (pix_x,pix_y)
//     vga_rgb     out 6   registered, blanked color
//     hsync       out 1   registered horizontal sync
//     vsync       out 1   registered vertical sync
//     frame       out 8   frame count for animated flags
//     frame_start out 1   high while at (0,0)
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY   = H_DISPLAY_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_DISPLAY   = V_DISPLAY_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               display_on,
  input  logic [COLOR_W-1:0] color_in,
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic [7:0]         frame,
  output logic               frame_start
);

  // Totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  // ---------------------------------------------------------------------
  // Coordinate counters: vertical advances only on the horizontal wrap,
  // so v_wrap marks the last pixel of the frame.
  // ---------------------------------------------------------------------
  vga_wrap_counter #(.MAX(H_MAX)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .count (pix_x),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.MAX(V_MAX)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_wrap),
    .count (pix_y),
    .wrap  (v_wrap)
  );

  assign display_on  = (pix_x < H_VIS) && (pix_y < V_VIS);
  assign frame_start = (pix_x == '0) && (pix_y == '0);

  // ---------------------------------------------------------------------
  // Stage 0: sync decode from the current coordinates.
  // ---------------------------------------------------------------------
  logic hs_active;
  logic vs_active;

  assign hs_active = (pix_x >= HS_START) && (pix_x < HS_END);
  assign vs_active = (pix_y >= VS_START) && (pix_y < VS_END);

  // ---------------------------------------------------------------------
  // Stage 1: output register. Color and both syncs share one flop stage
  // so they stay cycle-aligned at the pins.
  // ---------------------------------------------------------------------
  color_t vga_rgb_reg;
  color_t vga_rgb_next;
  logic   hsync_reg;
  logic   hsync_next;
  logic   vsync_reg;
  logic   vsync_next;

  always_comb begin
    vga_rgb_next = display_on ? color_in : BLACK;
    hsync_next   = sync_level(hs_active, SYNC_ACTIVE);
    vsync_next   = sync_level(vs_active, SYNC_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb_reg <= BLACK;
      hsync_reg   <= ~SYNC_ACTIVE;
      vsync_reg   <= ~SYNC_ACTIVE;
    end else begin
      vga_rgb_reg <= vga_rgb_next;
      hsync_reg   <= hsync_next;
      vsync_reg   <= vsync_next;
    end
  end

  assign vga_rgb = vga_rgb_reg;
  assign hsync   = hsync_reg;
  assign vsync   = vsync_reg;

  // ---------------------------------------------------------------------
  // Frame counter (optional).
  // ---------------------------------------------------------------------
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_reg <= 8'd0;
    end else if (v_wrap) begin
      frame_reg <= frame_reg + 8'd1;
    end
  end

  assign frame = frame_reg;
`else
  // End-of-frame strobe has no consumer without the counter.
  logic frame_end_unused;
  assign frame_end_unused = v_wrap;
  assign frame            = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
//   Two instances on one clock:
//     dut   - default 640x480 timing, active-low sync; reset, one full line
//             with a constant color, display/blank and hsync boundaries,
//             mid-line reset.
//     dut_s - shrunken timing (15x8 = 120 cycles/frame), active-high sync,
//             driven by a two-band flag; 256+ frames for vertical wrap,
//             vsync, frame_start and frame counter wrap, then mid-frame reset.
module tb_vga_timing;

  // Small-instance geometry
  localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_D = 4, SV_F = 1, SV_S = 2, SV_B = 1;
  localparam int SH_T = SH_D + SH_F + SH_S + SH_B;  // 15
  localparam int SV_T = SV_D + SV_F + SV_S + SV_B;  // 8
  localparam int S_FRAME = SH_T * SV_T;             // 120

`ifdef VGA_FRAME_COUNTER_EN
  localparam bit FRAME_EN = 1'b1;
`else
  localparam bit FRAME_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic       display_on;
  logic [5:0] color_in;
  logic [5:0] vga_rgb;
  logic       hsync, vsync;
  logic [7:0] frame;
  logic       frame_start;

  // Small instance signals
  logic       reset_s;
  logic [9:0] pix_x_s, pix_y_s;
  logic       display_on_s;
  logic [5:0] color_in_s;
  logic [5:0] vga_rgb_s;
  logic       hsync_s, vsync_s;
  logic [7:0] frame_s;
  logic       frame_start_s;

  vga_timing dut (
    .clk         (clk),
    .reset       (reset),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .display_on  (display_on),
    .color_in    (color_in),
    .vga_rgb     (vga_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame       (frame),
    .frame_start (frame_start)
  );

  vga_timing #(
    .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .clk         (clk),
    .reset       (reset_s),
    .pix_x       (pix_x_s),
    .pix_y       (pix_y_s),
    .display_on  (display_on_s),
    .color_in    (color_in_s),
    .vga_rgb     (vga_rgb_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .frame       (frame_s),
    .frame_start (frame_start_s)
  );

  // Model flag: upper half 6'h30, lower half 6'h0C.
  assign color_in_s = (pix_y_s < 10'(SV_D / 2)) ? 6'h30 : 6'h0C;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Default 640x480 instance
  // ---------------------------------------------------------------------
  task automatic run_default();
    int rgb_bad, hs_bad, vs_bad, x_bad, hs_low, first_low;
    int px, exp_rgb, exp_hs;

    reset    = 1'b1;
    color_in = 6'h2A;
    repeat (5) tick();
    chk("rst_pix_x",       32'(pix_x), 0);
    chk("rst_pix_y",       32'(pix_y), 0);
    chk("rst_vga_rgb",     32'(vga_rgb), 0);
    chk("rst_hsync",       32'(hsync), 1);
    chk("rst_vsync",       32'(vsync), 1);
    chk("rst_frame",       32'(frame), 0);
    chk("rst_display_on",  32'(display_on), 1);
    chk("rst_frame_start", 32'(frame_start), 1);
    $display("reset: x=%0d y=%0d rgb=%0h hs=%0b vs=%0b", pix_x, pix_y, vga_rgb, hsync, vsync);

    reset = 1'b0;
    rgb_bad = 0; hs_bad = 0; vs_bad = 0; x_bad = 0; hs_low = 0; first_low = -1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      px      = k - 1;  // column the output stage is showing
      exp_rgb = (px < 640) ? 32'h2A : 0;
      exp_hs  = (px >= 656 && px < 752) ? 0 : 1;
      if (int'(vga_rgb) != exp_rgb) rgb_bad++;
      if (int'(hsync) != exp_hs) hs_bad++;
      if (vsync !== 1'b1) vs_bad++;
      if (int'(pix_x) != k % 800) x_bad++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(pix_x);
      end
      if (k == 1) begin
        chk("first_x_after_release", 32'(pix_x), 1);
        chk("first_rgb_is_0_0",      32'(vga_rgb), 32'h2A);
        chk("frame_start_low",       32'(frame_start), 0);
      end
      if (k == 639) chk("display_on_x639", 32'(display_on), 1);
      if (k == 640) chk("display_on_x640", 32'(display_on), 0);
      if (k == 641) chk("rgb_blank_x640",  32'(vga_rgb), 0);
    end
    chk("line_rgb_errs",  32'(rgb_bad), 0);
    chk("line_hs_errs",   32'(hs_bad), 0);
    chk("line_vs_errs",   32'(vs_bad), 0);
    chk("line_x_errs",    32'(x_bad), 0);
    chk("hs_low_cycles",  32'(hs_low), 96);
    chk("hs_first_low_x", 32'(first_low), 657);
    chk("line_wrap_x",    32'(pix_x), 0);
    chk("line_wrap_y",    32'(pix_y), 1);
    chk("no_fs_line1",    32'(frame_start), 0);
    $display("line: rgb_errs=%0d hs_low=%0d first_low_x=%0d y=%0d", rgb_bad, hs_low, first_low, pix_y);

    repeat (300) tick();
    chk("pre_reset_x", 32'(pix_x), 300);
    chk("pre_reset_y", 32'(pix_y), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_x",   32'(pix_x), 0);
    chk("midreset_y",   32'(pix_y), 0);
    chk("midreset_rgb", 32'(vga_rgb), 0);
    chk("midreset_hs",  32'(hsync), 1);
    chk("midreset_fr",  32'(frame), 0);
    chk("midreset_fs",  32'(frame_start), 1);
    tick();
    chk("post_midreset_x",   32'(pix_x), 1);
    chk("post_midreset_rgb", 32'(vga_rgb), 32'h2A);
    $display("midreset: x=%0d y=%0d rgb=%0h", pix_x, pix_y, vga_rgb);
  endtask

  // ---------------------------------------------------------------------
  // Small 15x8 instance, active-high sync
  // ---------------------------------------------------------------------
  task automatic run_small();
    int xy_bad, rgb_bad, hs_bad, vs_bad, fr_bad, fs_cnt, vs_act, fs_bad;
    int p, px, py, exp_rgb, exp_hs, exp_vs, exp_fr;
    int n_cyc;

    n_cyc   = 256 * S_FRAME + 5;
    reset_s = 1'b1;
    repeat (5) tick();
    chk("s_rst_hsync", 32'(hsync_s), 0);
    chk("s_rst_vsync", 32'(vsync_s), 0);
    chk("s_rst_rgb",   32'(vga_rgb_s), 0);
    chk("s_rst_y",     32'(pix_y_s), 0);
    reset_s = 1'b0;

    xy_bad = 0; rgb_bad = 0; hs_bad = 0; vs_bad = 0; fr_bad = 0;
    fs_cnt = 0; vs_act = 0; fs_bad = 0;
    for (int c = 1; c <= n_cyc; c++) begin
      tick();
      p  = c - 1;
      px = p % SH_T;
      py = (p / SH_T) % SV_T;
      exp_rgb = (px < SH_D && py < SV_D) ? ((py < SV_D / 2) ? 32'h30 : 32'h0C) : 0;
      exp_hs  = (px >= SH_D + SH_F && px < SH_D + SH_F + SH_S) ? 1 : 0;
      exp_vs  = (py >= SV_D + SV_F && py < SV_D + SV_F + SV_S) ? 1 : 0;
      exp_fr  = FRAME_EN ? (c / S_FRAME) % 256 : 0;
      if (int'(pix_x_s) != c % SH_T || int'(pix_y_s) != (c / SH_T) % SV_T) xy_bad++;
      if (int'(vga_rgb_s) != exp_rgb) rgb_bad++;
      if (int'(hsync_s) != exp_hs) hs_bad++;
      if (int'(vsync_s) != exp_vs) vs_bad++;
      if (int'(frame_s) != exp_fr) fr_bad++;
      if (vsync_s === 1'b1) vs_act++;
      if (frame_start_s === 1'b1) fs_cnt++;
      if ((frame_start_s === 1'b1) != (c % S_FRAME == 0)) fs_bad++;
      // Color band edge: last blank pixel of row 1, then first row-2 pixel.
      if (c == 2 * SH_T + 1) chk("s_band_first_0C", 32'(vga_rgb_s), 32'h0C);
      if (c == 2 * SH_T)     chk("s_band_prev_blank", 32'(vga_rgb_s), 0);
      if (c == S_FRAME) begin
        chk("s_frame_wrap_x", 32'(pix_x_s), 0);
        chk("s_frame_wrap_y", 32'(pix_y_s), 0);
      end
      if (c == 255 * S_FRAME) chk("s_frame_255", 32'(frame_s), FRAME_EN ? 255 : 0);
    end
    chk("s_xy_errs",     32'(xy_bad), 0);
    chk("s_rgb_errs",    32'(rgb_bad), 0);
    chk("s_hs_errs",     32'(hs_bad), 0);
    chk("s_vs_errs",     32'(vs_bad), 0);
    chk("s_frame_errs",  32'(fr_bad), 0);
    chk("s_fs_pos_errs", 32'(fs_bad), 0);
    chk("s_fs_count",    32'(fs_cnt), 256);
    chk("s_vs_active",   32'(vs_act), 256 * SV_S * SH_T);
    chk("s_frame_wrapped", 32'(frame_s), 0);
    $display("small: frames=256 fs=%0d vs_act=%0d frame=%0d rgb_errs=%0d", fs_cnt, vs_act, frame_s, rgb_bad);

    // Mid-frame reset (currently at cycle 5 of a frame).
    reset_s = 1'b1;
    tick();
    reset_s = 1'b0;
    chk("s_midreset_x",  32'(pix_x_s), 0);
    chk("s_midreset_y",  32'(pix_y_s), 0);
    chk("s_midreset_rgb", 32'(vga_rgb_s), 0);
    chk("s_midreset_fr", 32'(frame_s), 0);
    $display("small midreset: x=%0d y=%0d frame=%0d", pix_x_s, pix_y_s, frame_s);
  endtask

  initial begin
    reset    = 1'b1;
    reset_s  = 1'b1;
    color_in = 6'h00;
    fork
      run_default();
      run_small();
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net: the directed sequence is bounded, this only guards a hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got %0d checks expected completion", n_total);
    $fatal(1, "timeout");
  end

endmodule
